// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: walks the ROM from its PC, assembles 1- or 2-byte
// instructions, issues them over valid/ready and applies branches or halts at handshake.
module instr_fetch_sequencer #(
  parameter logic [4:0]  START_ADDR    = 5'd0,
  parameter logic [15:0] TWO_BYTE_MASK = 16'h0018,
  parameter logic [3:0]  HALT_OPCODE   = 4'h1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [4:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       instr_valid,
  input  logic       exec_ready,
  output logic [3:0] opcode,
  output logic [3:0] operand,
  output logic [7:0] imm,
  output logic [4:0] instr_addr,
  input  logic       branch_en,
  input  logic [4:0] branch_target,
  output logic       busy,
  output logic       halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH1,
    FETCH2,
    ISSUE,
    HALTED
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] pc_q, pc_d;
  logic [3:0] opcode_q, opcode_d;
  logic [3:0] operand_q, operand_d;
  logic [7:0] imm_q, imm_d;
  logic [4:0] instr_addr_q, instr_addr_d;
  logic       instr_valid_q, instr_valid_d;
  logic       busy_q, busy_d;
  logic       halted_q, halted_d;
  logic       handshake;

  assign handshake = (state_q == ISSUE) && exec_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= START_ADDR;
      opcode_q      <= '0;
      operand_q     <= '0;
      imm_q         <= '0;
      instr_addr_q  <= START_ADDR;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      opcode_q      <= opcode_d;
      operand_q     <= operand_d;
      imm_q         <= imm_d;
      instr_addr_q  <= instr_addr_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
    end
  end

  // Next state, PC and instruction fields.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    opcode_d     = opcode_q;
    operand_d    = operand_q;
    imm_d        = imm_q;
    instr_addr_d = instr_addr_q;
    unique case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          pc_d    = START_ADDR;
          state_d = FETCH1;
        end
      end
      FETCH1: begin
        opcode_d     = rom_data[7:4];
        operand_d    = rom_data[3:0];
        imm_d        = '0;
        instr_addr_d = pc_q;
        pc_d         = pc_q + 5'd1;
        state_d      = TWO_BYTE_MASK[rom_data[7:4]] ? FETCH2 : ISSUE;
      end
      FETCH2: begin
        imm_d   = rom_data;
        pc_d    = pc_q + 5'd1;
        state_d = ISSUE;
      end
      ISSUE: begin
        // Halt takes priority over a branch presented with the same handshake.
        if (handshake) begin
          if (opcode_q == HALT_OPCODE) begin
            state_d = HALTED;
          end else begin
            if (branch_en) pc_d = branch_target;
            state_d = FETCH1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered by decoding the upcoming state.
  always_comb begin
    instr_valid_d = (state_d == ISSUE);
    busy_d        = (state_d == FETCH1) || (state_d == FETCH2) || (state_d == ISSUE);
    halted_d      = (state_d == HALTED);
  end

  assign rom_addr    = pc_q;
  assign instr_valid = instr_valid_q;
  assign opcode      = opcode_q;
  assign operand     = operand_q;
  assign imm         = imm_q;
  assign instr_addr  = instr_addr_q;
  assign busy        = busy_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer: cycle-by-cycle vector table plus
// hand sequences for reset during fetch and PC wrap-around.
module tb_instr_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] rom_addr;
  logic [7:0] rom_data;
  logic       instr_valid;
  logic       exec_ready;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic [7:0] imm;
  logic [4:0] instr_addr;
  logic       branch_en;
  logic [4:0] branch_target;
  logic       busy;
  logic       halted;

  logic [7:0] rom [32];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  instr_fetch_sequencer #(
    .START_ADDR   (5'd0),
    .TWO_BYTE_MASK(16'h0018),
    .HALT_OPCODE  (4'h1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .instr_valid  (instr_valid),
    .exec_ready   (exec_ready),
    .opcode       (opcode),
    .operand      (operand),
    .imm          (imm),
    .instr_addr   (instr_addr),
    .branch_en    (branch_en),
    .branch_target(branch_target),
    .busy         (busy),
    .halted       (halted)
  );

  typedef struct {
    logic       st;
    logic       rdy;
    logic       br;
    logic [4:0] tgt;
    logic       v;
    logic [3:0] op;
    logic [3:0] opd;
    logic [7:0] im;
    logic [4:0] ia;
    logic [4:0] ra;
    logic       bsy;
    logic       hlt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic st, input logic rdy, input logic br,
                              input logic [4:0] tgt, input logic v, input logic [3:0] op,
                              input logic [3:0] opd, input logic [7:0] im,
                              input logic [4:0] ia, input logic [4:0] ra,
                              input logic bsy, input logic hlt);
    vec_t r;
    r = '{st, rdy, br, tgt, v, op, opd, im, ia, ra, bsy, hlt};
    vecs.push_back(r);
  endfunction

  // Packs all visible outputs: valid, opcode, operand, imm, instr_addr, rom_addr, busy, halted.
  function automatic logic [28:0] pack(input logic v, input logic [3:0] op, input logic [3:0] opd,
                                       input logic [7:0] im, input logic [4:0] ia,
                                       input logic [4:0] ra, input logic bsy, input logic hlt);
    return {v, op, opd, im, ia, ra, bsy, hlt};
  endfunction

  task automatic check(input string name, input logic [28:0] exp);
    logic [28:0] act;
    act = pack(instr_valid, opcode, operand, imm, instr_addr, rom_addr, busy, halted);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got v=%b op=%h opd=%h imm=%h ia=%0d ra=%0d busy=%b halt=%b, expected v=%b op=%h opd=%h imm=%h ia=%0d ra=%0d busy=%b halt=%b",
               name, act[28], act[27:24], act[23:20], act[19:12], act[11:7], act[6:2], act[1], act[0],
               exp[28], exp[27:24], exp[23:20], exp[19:12], exp[11:7], exp[6:2], exp[1], exp[0]);
    end
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    int n;
    n = 0;
    @(negedge clk);
    while (instr_valid !== 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (instr_valid !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s: instr_valid=%b after %0d cycles, expected 1", name, instr_valid, n);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    rom[0]  = 8'h35; rom[1]  = 8'h00; rom[2]  = 8'h20; rom[3] = 8'h57; rom[4] = 8'h62;
    rom[10] = 8'h4C; rom[11] = 8'h99; rom[12] = 8'h70; rom[21] = 8'h1F;
    rom[31] = 8'h40;

    //   st rdy br tgt    v op    opd   imm    ia  ra  bsy hlt
    add(1, 0, 0, 5'd0,   0, 4'h0, 4'h0, 8'h00, 0,  0,  0, 0);  // reset state, start
    add(0, 1, 0, 5'd0,   0, 4'h0, 4'h0, 8'h00, 0,  0,  1, 0);  // FETCH1 @0
    add(0, 1, 0, 5'd0,   0, 4'h3, 4'h5, 8'h00, 0,  1,  1, 0);  // FETCH2
    add(0, 1, 0, 5'd0,   1, 4'h3, 4'h5, 8'h00, 0,  2,  1, 0);  // ISSUE 35 00
    add(0, 0, 0, 5'd0,   0, 4'h3, 4'h5, 8'h00, 0,  2,  1, 0);  // FETCH1 @2
    add(0, 0, 0, 5'd0,   1, 4'h2, 4'h0, 8'h00, 2,  3,  1, 0);  // ISSUE 20 stalled
    add(1, 0, 0, 5'd0,   1, 4'h2, 4'h0, 8'h00, 2,  3,  1, 0);  // start ignored
    add(0, 0, 0, 5'd0,   1, 4'h2, 4'h0, 8'h00, 2,  3,  1, 0);
    add(0, 0, 0, 5'd0,   1, 4'h2, 4'h0, 8'h00, 2,  3,  1, 0);
    add(0, 0, 0, 5'd0,   1, 4'h2, 4'h0, 8'h00, 2,  3,  1, 0);
    add(0, 1, 0, 5'd0,   1, 4'h2, 4'h0, 8'h00, 2,  3,  1, 0);  // ready rises
    add(0, 1, 0, 5'd0,   0, 4'h2, 4'h0, 8'h00, 2,  3,  1, 0);  // FETCH1 @3
    add(0, 1, 0, 5'd0,   1, 4'h5, 4'h7, 8'h00, 3,  4,  1, 0);  // ISSUE 57
    add(0, 1, 0, 5'd0,   0, 4'h5, 4'h7, 8'h00, 3,  4,  1, 0);  // FETCH1 @4
    add(0, 1, 1, 5'd10,  1, 4'h6, 4'h2, 8'h00, 4,  5,  1, 0);  // ISSUE 62, branch to 10
    add(0, 1, 0, 5'd0,   0, 4'h6, 4'h2, 8'h00, 4,  10, 1, 0);  // FETCH1 @10
    add(0, 1, 0, 5'd0,   0, 4'h4, 4'hC, 8'h00, 10, 11, 1, 0);  // FETCH2
    add(0, 1, 0, 5'd0,   1, 4'h4, 4'hC, 8'h99, 10, 12, 1, 0);  // ISSUE 4C 99
    add(0, 1, 0, 5'd0,   0, 4'h4, 4'hC, 8'h99, 10, 12, 1, 0);  // FETCH1 @12
    add(0, 1, 1, 5'd21,  1, 4'h7, 4'h0, 8'h00, 12, 13, 1, 0);  // ISSUE 70, branch to 21
    add(0, 1, 0, 5'd0,   0, 4'h7, 4'h0, 8'h00, 12, 21, 1, 0);  // FETCH1 @21
    add(0, 1, 1, 5'd5,   1, 4'h1, 4'hF, 8'h00, 21, 22, 1, 0);  // ISSUE halt, branch ignored
    add(0, 0, 0, 5'd0,   0, 4'h1, 4'hF, 8'h00, 21, 22, 0, 1);  // HALTED
    add(1, 0, 0, 5'd0,   0, 4'h1, 4'hF, 8'h00, 21, 22, 0, 1);  // restart
    add(0, 0, 0, 5'd0,   0, 4'h1, 4'hF, 8'h00, 21, 0,  1, 0);  // FETCH1 @0
    add(0, 0, 0, 5'd0,   0, 4'h3, 4'h5, 8'h00, 0,  1,  1, 0);  // FETCH2
    add(0, 0, 0, 5'd0,   1, 4'h3, 4'h5, 8'h00, 0,  2,  1, 0);  // ISSUE, held

    reset = 1'b1; start = 1'b0; exec_ready = 1'b0; branch_en = 1'b0; branch_target = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      start         = vecs[i].st;
      exec_ready    = vecs[i].rdy;
      branch_en     = vecs[i].br;
      branch_target = vecs[i].tgt;
      @(negedge clk);
      check($sformatf("vec%0d", i), pack(vecs[i].v, vecs[i].op, vecs[i].opd, vecs[i].im,
                                         vecs[i].ia, vecs[i].ra, vecs[i].bsy, vecs[i].hlt));
      @(posedge clk);
      #1;
    end

    // Asynchronous reset from ISSUE, then again from FETCH2.
    start = 1'b0; exec_ready = 1'b0; branch_en = 1'b0;
    #2 reset = 1'b1;
    #1 check("reset_in_issue", pack(0, 4'h0, 4'h0, 8'h00, 5'd0, 5'd0, 0, 0));
    #1 reset = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    check("in_fetch2", pack(0, 4'h3, 4'h5, 8'h00, 5'd0, 5'd1, 1, 0));
    reset = 1'b1;
    #1 check("reset_in_fetch2", pack(0, 4'h0, 4'h0, 8'h00, 5'd0, 5'd0, 0, 0));
    #1 reset = 1'b0;
    exec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("idle_after_reset%0d", i), pack(0, 4'h0, 4'h0, 8'h00, 5'd0, 5'd0, 0, 0));
    end

    // PC wrap: branch to 31, two-byte instruction takes its immediate from address 0.
    rom[0] = 8'hAB;
    @(posedge clk); #1 start = 1'b1; branch_en = 1'b1; branch_target = 5'd31;
    @(posedge clk); #1 start = 1'b0;
    wait_valid("wait_ab", 8);
    check("issue_ab", pack(1, 4'hA, 4'hB, 8'h00, 5'd0, 5'd1, 1, 0));
    @(posedge clk); #1 branch_en = 1'b0;
    @(negedge clk);
    check("fetch1_at_31", pack(0, 4'hA, 4'hB, 8'h00, 5'd0, 5'd31, 1, 0));
    wait_valid("wait_wrap", 8);
    check("issue_wrap", pack(1, 4'h4, 4'h0, 8'hAB, 5'd31, 5'd1, 1, 0));
    @(posedge clk); #1;
    @(negedge clk);
    check("fetch1_after_wrap", pack(0, 4'h4, 4'h0, 8'hAB, 5'd31, 5'd1, 1, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
